// File: rtl/service_rx_buffer.sv
// Receive buffer for the service protocol decoder. Payload words are written
// speculatively into a circular store and become visible to the reader only
// when the packet ends with a good checksum; bad or refused packets roll back.
module service_rx_buffer #(
  parameter logic [7:0]  MY_ADDR    = 8'hAB,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_start,
  input  logic [7:0]            pkt_addr,
  input  logic [7:0]            pkt_cmd,
  input  logic                  in_request,
  input  logic [15:0]           in_data,
  output logic                  in_done,
  input  logic                  pkt_end,
  input  logic                  pkt_err,
  output logic                  cmd_valid,
  output logic [7:0]            cmd_addr,
  output logic [7:0]            cmd_code,
  output logic [DEPTH_LOG2:0]   cmd_len,
  input  logic                  cmd_ack,
  input  logic                  rd_request,
  output logic [15:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   used_words,
  output logic [7:0]            drop_count
);

  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, wtmp_q, wtmp_d, rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   used_q, used_d, len_q, len_d, cmd_len_q, cmd_len_d;
  logic [7:0]            drop_q, drop_d, cmd_addr_q, cmd_addr_d, cmd_code_q, cmd_code_d;
  logic [7:0]            pend_addr_q, pend_addr_d, pend_code_q, pend_code_d;
  logic                  cmd_valid_q, cmd_valid_d, in_done_q, in_done_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [15:0]           rd_data_q, rd_data_d;
  logic [15:0]           mem [2**DEPTH_LOG2];

  logic                  wr_en, pop;
  logic [1:0]            drop_inc;
  logic [8:0]            drop_sum;
  logic [DEPTH_LOG2:0]   commit_words, spec_occ;

  // Committed plus open-packet words: what the store would hold if committed now.
  assign spec_occ = used_q + len_q;

  // Next-state, pointer and descriptor logic; a new header always wins over
  // any end/error/word pulse arriving in the same cycle.
  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    wtmp_d       = wtmp_q;
    rptr_d       = rptr_q;
    len_d        = len_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_code_d   = cmd_code_q;
    cmd_len_d    = cmd_len_q;
    pend_addr_d  = pend_addr_q;
    pend_code_d  = pend_code_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    in_done_d    = in_request;
    wr_en        = 1'b0;
    drop_inc     = 2'd0;
    commit_words = '0;

    pop = rd_request && (used_q != '0);
    if (pop) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem[rptr_q];
      rptr_d     = rptr_q + 1'b1;
    end

    if (cmd_ack && cmd_valid_q) cmd_valid_d = 1'b0;

    if (pkt_start) begin
      wtmp_d = wptr_q;
      if (state_q == RECV) drop_inc = drop_inc + 2'd1;
      if (((pkt_addr == MY_ADDR) || (pkt_addr == 8'hFF)) && !cmd_valid_q) begin
        state_d     = RECV;
        pend_addr_d = pkt_addr;
        pend_code_d = pkt_cmd;
        len_d       = '0;
      end else begin
        state_d  = DROP;
        drop_inc = drop_inc + 2'd1;
      end
    end else begin
      case (state_q)
        RECV: begin
          if (pkt_err) begin
            wtmp_d   = wptr_q;
            drop_inc = 2'd1;
            state_d  = IDLE;
          end else if (in_request && (spec_occ >= FULL)) begin
            wtmp_d   = wptr_q;
            drop_inc = 2'd1;
            state_d  = DROP;
          end else begin
            if (in_request) begin
              wr_en  = 1'b1;
              wtmp_d = wtmp_q + 1'b1;
              len_d  = len_q + 1'b1;
            end
            // Commit includes a word arriving alongside the end pulse.
            if (pkt_end) begin
              wptr_d       = wtmp_d;
              commit_words = len_d;
              cmd_valid_d  = 1'b1;
              cmd_addr_d   = pend_addr_q;
              cmd_code_d   = pend_code_q;
              cmd_len_d    = len_d;
              state_d      = IDLE;
            end
          end
        end
        DROP: if (pkt_end || pkt_err) state_d = IDLE;
        default: ;
      endcase
    end

    used_d   = used_q + commit_words - {{DEPTH_LOG2{1'b0}}, pop};
    drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      wtmp_q      <= '0;
      rptr_q      <= '0;
      used_q      <= '0;
      len_q       <= '0;
      drop_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_code_q  <= '0;
      cmd_len_q   <= '0;
      pend_addr_q <= '0;
      pend_code_q <= '0;
      in_done_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      wtmp_q      <= wtmp_d;
      rptr_q      <= rptr_d;
      used_q      <= used_d;
      len_q       <= len_d;
      drop_q      <= drop_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_code_q  <= cmd_code_d;
      cmd_len_q   <= cmd_len_d;
      pend_addr_q <= pend_addr_d;
      pend_code_q <= pend_code_d;
      in_done_q   <= in_done_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Payload store; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wtmp_q] <= in_data;
  end

  assign in_done    = in_done_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_addr   = cmd_addr_q;
  assign cmd_code   = cmd_code_q;
  assign cmd_len    = cmd_len_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign used_words = used_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_service_rx_buffer.sv
// Bench for service_rx_buffer: fixed vector table, directed corner sequences,
// then random traffic against a queue-based reference model.
module tb_service_rx_buffer;

  localparam int DL = 2;

  logic          clk = 1'b0;
  logic          rst, pkt_start, in_request, pkt_end, pkt_err, cmd_ack, rd_request;
  logic [7:0]    pkt_addr, pkt_cmd;
  logic [15:0]   in_data;
  logic          in_done, cmd_valid, rd_valid;
  logic [7:0]    cmd_addr, cmd_code, drop_count;
  logic [DL:0]   cmd_len, used_words;
  logic [15:0]   rd_data;

  int checks = 0;
  int errors = 0;

  service_rx_buffer #(.MY_ADDR(8'hAB), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .pkt_addr(pkt_addr),
    .pkt_cmd(pkt_cmd), .in_request(in_request), .in_data(in_data),
    .in_done(in_done), .pkt_end(pkt_end), .pkt_err(pkt_err),
    .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_code(cmd_code),
    .cmd_len(cmd_len), .cmd_ack(cmd_ack), .rd_request(rd_request),
    .rd_data(rd_data), .rd_valid(rd_valid), .used_words(used_words),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst; logic start; logic [7:0] addr; logic [7:0] cmd;
    logic req; logic [15:0] data; logic pend; logic perr; logic ack; logic rd;
  } in_t;

  typedef struct packed {
    logic start; logic [7:0] addr; logic [7:0] cmd; logic req; logic [15:0] data;
    logic pend; logic perr; logic ack; logic rd;
    logic e_done; logic e_cv; logic [7:0] e_len; logic [7:0] e_addr; logic [7:0] e_code;
    logic [7:0] e_used; logic [7:0] e_drop; logic e_rv; logic [15:0] e_rdata;
  } vec_t;

  // Reference model: committed words, open-packet words, descriptor, counters.
  logic [15:0] cq[$];
  logic [15:0] sq[$];
  int          m_mode;          // 0 waiting for header, 1 collecting, 2 discarding
  logic [7:0]  m_paddr, m_pcode, m_addr, m_code;
  int          m_len, m_drop;
  logic        m_cv, m_done, m_rv;
  logic [15:0] m_rdata;

  task automatic model_reset();
    cq.delete(); sq.delete();
    m_mode = 0; m_paddr = 0; m_pcode = 0; m_addr = 0; m_code = 0;
    m_len = 0; m_drop = 0; m_cv = 0; m_done = 0; m_rv = 0; m_rdata = 0;
  endtask

  task automatic model_step(input in_t i);
    int   occ, nd;
    logic had_cv;
    if (i.rst) begin model_reset(); return; end
    occ = cq.size() + sq.size();
    had_cv = m_cv;
    nd = 0;
    m_done = i.req;
    m_rv = 0;
    if (i.rd && cq.size() > 0) begin m_rv = 1; m_rdata = cq.pop_front(); end
    if (i.ack && had_cv) m_cv = 0;
    if (i.start) begin
      if (m_mode == 1) nd++;
      sq.delete();
      if ((i.addr == 8'hAB || i.addr == 8'hFF) && !had_cv) begin
        m_mode = 1; m_paddr = i.addr; m_pcode = i.cmd;
      end else begin
        m_mode = 2; nd++;
      end
    end else if (m_mode == 1) begin
      if (i.perr) begin
        sq.delete(); nd++; m_mode = 0;
      end else if (i.req && occ >= (1 << DL)) begin
        sq.delete(); nd++; m_mode = 2;
      end else begin
        if (i.req) sq.push_back(i.data);
        if (i.pend) begin
          m_len = sq.size();
          foreach (sq[k]) cq.push_back(sq[k]);
          sq.delete();
          m_cv = 1; m_addr = m_paddr; m_code = m_pcode; m_mode = 0;
        end
      end
    end else if (m_mode == 2) begin
      if (i.pend || i.perr) m_mode = 0;
    end
    m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
  endtask

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input in_t i);
    rst = i.rst; pkt_start = i.start; pkt_addr = i.addr; pkt_cmd = i.cmd;
    in_request = i.req; in_data = i.data; pkt_end = i.pend; pkt_err = i.perr;
    cmd_ack = i.ack; rd_request = i.rd;
    model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic t_idle();  in_t r = '0; tick(r); endtask
  task automatic t_end();   in_t r = '0; r.pend = 1; tick(r); endtask
  task automatic t_ack();   in_t r = '0; r.ack = 1; tick(r); endtask
  task automatic t_rd();    in_t r = '0; r.rd = 1; tick(r); endtask
  task automatic t_word(input logic [15:0] d);
    in_t r = '0; r.req = 1; r.data = d; tick(r);
  endtask
  task automatic t_start(input logic [7:0] a, input logic [7:0] c);
    in_t r = '0; r.start = 1; r.addr = a; r.cmd = c; tick(r);
  endtask

  vec_t tbl[16];

  initial begin
    in_t r;
    model_reset();
    r = '0; r.rst = 1;
    tick(r); tick(r);
    chk("rst.in_done", in_done, 0);   chk("rst.cmd_valid", cmd_valid, 0);
    chk("rst.cmd_len", cmd_len, 0);   chk("rst.used", used_words, 0);
    chk("rst.drop", drop_count, 0);   chk("rst.rd_valid", rd_valid, 0);
    chk("rst.rd_data", rd_data, 0);

    // Good packet, then bad-checksum packet followed by a good one.
    //          start addr   cmd   req data     pe pr ak rd | dn cv len   addr   code   used  drop  rv rdata
    tbl[0]  = '{1'b1,8'hAB,8'hA2,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd0,8'h00,8'h00,8'd0,8'd0,1'b0,16'h0000};
    tbl[1]  = '{1'b0,8'h00,8'h00,1'b1,16'hEFAB,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'd0,8'h00,8'h00,8'd0,8'd0,1'b0,16'h0000};
    tbl[2]  = '{1'b0,8'h00,8'h00,1'b1,16'h0001,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'd0,8'h00,8'h00,8'd0,8'd0,1'b0,16'h0000};
    tbl[3]  = '{1'b0,8'h00,8'h00,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,8'd2,8'hAB,8'hA2,8'd2,8'd0,1'b0,16'h0000};
    tbl[4]  = '{1'b0,8'h00,8'h00,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,8'd2,8'hAB,8'hA2,8'd1,8'd0,1'b1,16'hEFAB};
    tbl[5]  = '{1'b0,8'h00,8'h00,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,8'd2,8'hAB,8'hA2,8'd0,8'd0,1'b1,16'h0001};
    tbl[6]  = '{1'b0,8'h00,8'h00,1'b0,16'h0000,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,8'd2,8'hAB,8'hA2,8'd0,8'd0,1'b0,16'h0001};
    tbl[7]  = '{1'b1,8'hAB,8'hA2,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd2,8'hAB,8'hA2,8'd0,8'd0,1'b0,16'h0001};
    tbl[8]  = '{1'b0,8'h00,8'h00,1'b1,16'hEFAB,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'd2,8'hAB,8'hA2,8'd0,8'd0,1'b0,16'h0001};
    tbl[9]  = '{1'b0,8'h00,8'h00,1'b1,16'h0001,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'd2,8'hAB,8'hA2,8'd0,8'd0,1'b0,16'h0001};
    tbl[10] = '{1'b0,8'h00,8'h00,1'b0,16'h0000,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,8'd2,8'hAB,8'hA2,8'd0,8'd1,1'b0,16'h0001};
    tbl[11] = '{1'b1,8'hAB,8'h10,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,8'd2,8'hAB,8'hA2,8'd0,8'd1,1'b0,16'h0001};
    tbl[12] = '{1'b0,8'h00,8'h00,1'b1,16'h1234,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,8'd2,8'hAB,8'hA2,8'd0,8'd1,1'b0,16'h0001};
    tbl[13] = '{1'b0,8'h00,8'h00,1'b0,16'h0000,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,8'd1,8'hAB,8'h10,8'd1,8'd1,1'b0,16'h0001};
    tbl[14] = '{1'b0,8'h00,8'h00,1'b0,16'h0000,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,8'd1,8'hAB,8'h10,8'd0,8'd1,1'b1,16'h1234};
    tbl[15] = '{1'b0,8'h00,8'h00,1'b0,16'h0000,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,8'd1,8'hAB,8'h10,8'd0,8'd1,1'b0,16'h1234};

    for (int n = 0; n < 16; n++) begin
      r = '0;
      r.start = tbl[n].start; r.addr = tbl[n].addr; r.cmd = tbl[n].cmd;
      r.req = tbl[n].req; r.data = tbl[n].data; r.pend = tbl[n].pend;
      r.perr = tbl[n].perr; r.ack = tbl[n].ack; r.rd = tbl[n].rd;
      tick(r);
      chk($sformatf("tbl%0d.in_done", n), in_done, tbl[n].e_done);
      chk($sformatf("tbl%0d.cmd_valid", n), cmd_valid, tbl[n].e_cv);
      chk($sformatf("tbl%0d.cmd_len", n), cmd_len, tbl[n].e_len);
      chk($sformatf("tbl%0d.cmd_addr", n), cmd_addr, tbl[n].e_addr);
      chk($sformatf("tbl%0d.cmd_code", n), cmd_code, tbl[n].e_code);
      chk($sformatf("tbl%0d.used", n), used_words, tbl[n].e_used);
      chk($sformatf("tbl%0d.drop", n), drop_count, tbl[n].e_drop);
      chk($sformatf("tbl%0d.rd_valid", n), rd_valid, tbl[n].e_rv);
      chk($sformatf("tbl%0d.rd_data", n), rd_data, tbl[n].e_rdata);
    end

    // Address filter.
    t_start(8'h12, 8'h01); chk("flt.foreign_drop", drop_count, 2);
    t_end();               chk("flt.drop_end", drop_count, 2);
    t_start(8'hFF, 8'h55); t_word(16'hBEEF); t_end();
    chk("flt.bc_cv", cmd_valid, 1); chk("flt.bc_addr", cmd_addr, 8'hFF);
    chk("flt.bc_len", cmd_len, 1);  chk("flt.bc_used", used_words, 1);
    t_start(8'hAB, 8'h66); chk("flt.busy_drop", drop_count, 3);
    t_word(16'h1111); t_end();
    chk("flt.busy_used", used_words, 1); chk("flt.busy_code", cmd_code, 8'h55);
    t_rd(); chk("flt.rd", rd_data, 16'hBEEF); chk("flt.rv", rd_valid, 1);
    t_ack(); chk("flt.ack", cmd_valid, 0);

    // Overflow with pointer wrap: shift pointers to 2, fill 3, try 2 more.
    t_start(8'hAB, 8'h20); t_word(16'hC001); t_word(16'hC002); t_end();
    t_rd(); t_rd(); chk("ovf.pre_rd", rd_data, 16'hC002); t_ack();
    t_start(8'hAB, 8'h21); t_word(16'hA001); t_word(16'hA002); t_word(16'hA003); t_end();
    chk("ovf.used3", used_words, 3); chk("ovf.len3", cmd_len, 3);
    t_ack();
    t_start(8'hAB, 8'h22); t_word(16'hB001); chk("ovf.first_ok", drop_count, 3);
    t_word(16'hB002); chk("ovf.drop", drop_count, 4); chk("ovf.used_kept", used_words, 3);
    t_end(); chk("ovf.no_commit", cmd_valid, 0); chk("ovf.drop_once", drop_count, 4);
    t_rd(); chk("ovf.pop1", rd_data, 16'hA001);
    t_rd(); chk("ovf.pop2", rd_data, 16'hA002);
    t_rd(); chk("ovf.pop3", rd_data, 16'hA003); chk("ovf.empty", used_words, 0);
    t_rd(); chk("ovf.empty_rd", rd_valid, 0);

    // Word together with end pulse; header interrupting a packet.
    t_start(8'hAB, 8'h30); t_word(16'hD001);
    r = '0; r.req = 1; r.data = 16'hD002; r.pend = 1; tick(r);
    chk("sim.len", cmd_len, 2); chk("sim.used", used_words, 2); chk("sim.done", in_done, 1);
    t_rd(); t_rd(); chk("sim.last_word", rd_data, 16'hD002); t_ack();
    t_start(8'hAB, 8'h31); t_word(16'hE001);
    t_start(8'hAB, 8'h32); chk("int.drop", drop_count, 5);
    t_word(16'hE002); t_end();
    chk("int.cv", cmd_valid, 1); chk("int.code", cmd_code, 8'h32);
    chk("int.len", cmd_len, 1); chk("int.used", used_words, 1);
    t_rd(); chk("int.rd", rd_data, 16'hE002); t_ack();

    // Reset mid-packet with committed data present.
    t_start(8'hAB, 8'h40); t_word(16'hF000); t_end(); t_ack();
    t_start(8'hAB, 8'h41); t_word(16'hF001);
    r = '0; r.rst = 1; tick(r);
    chk("mrst.cv", cmd_valid, 0);   chk("mrst.len", cmd_len, 0);
    chk("mrst.addr", cmd_addr, 0);  chk("mrst.code", cmd_code, 0);
    chk("mrst.used", used_words, 0); chk("mrst.drop", drop_count, 0);
    chk("mrst.done", in_done, 0);   chk("mrst.rdata", rd_data, 0);
    t_rd(); chk("mrst.rd_none", rd_valid, 0);
    t_idle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      r = '0;
      r.start = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: r.addr = 8'hAB;
        1: r.addr = 8'hFF;
        2: r.addr = 8'h12;
        default: r.addr = 8'($urandom);
      endcase
      r.cmd  = 8'($urandom);
      r.req  = ($urandom_range(0, 1) == 1);
      r.data = 16'($urandom);
      r.pend = ($urandom_range(0, 9) == 0);
      r.perr = ($urandom_range(0, 19) == 0);
      r.ack  = ($urandom_range(0, 5) == 0);
      r.rd   = ($urandom_range(0, 2) == 0);
      tick(r);
      chk($sformatf("rnd%0d.in_done", n), in_done, m_done);
      chk($sformatf("rnd%0d.cmd_valid", n), cmd_valid, m_cv);
      chk($sformatf("rnd%0d.cmd_len", n), cmd_len, m_len);
      chk($sformatf("rnd%0d.cmd_addr", n), cmd_addr, m_addr);
      chk($sformatf("rnd%0d.cmd_code", n), cmd_code, m_code);
      chk($sformatf("rnd%0d.used", n), used_words, cq.size());
      chk($sformatf("rnd%0d.drop", n), drop_count, m_drop);
      chk($sformatf("rnd%0d.rd_valid", n), rd_valid, m_rv);
      if (m_rv) chk($sformatf("rnd%0d.rd_data", n), rd_data, m_rdata);
    end

    // Drop counter saturation.
    for (int n = 0; n < 260; n++) begin
      t_start(8'h12, 8'h00);
      t_end();
    end
    chk("sat.drop", drop_count, 8'hFF);
    chk("sat.model", drop_count, m_drop);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
